// File: rtl/alu_ctrl_seq_if.sv
// Request/response bundle between the control unit (master) and alu_ctrl_seq (slave).
interface alu_ctrl_seq_if #(
  parameter int WIDTH   = 24,
  parameter int FUNCT_W = 4,
  parameter int OPC_W   = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         alu_op;
  logic [FUNCT_W-1:0] funct;
  logic [OPC_W-1:0]   opcode;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               out_valid;
  logic [3:0]         alu_ctrl;
  logic [WIDTH-1:0]   mul_result;
  logic               mul_ovf;
  logic               illegal;

  modport master (
    output in_valid, alu_op, funct, opcode, op_a, op_b,
    input  in_ready, out_valid, alu_ctrl, mul_result, mul_ovf, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct, opcode, op_a, op_b,
    output in_ready, out_valid, alu_ctrl, mul_result, mul_ovf, illegal
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU-control decoder with an iterative shift-add unsigned multiplier.
// Optional macro ALU_CTRL_ILLEGAL_EN flags unsupported encodings instead of falling back to ADD.
module alu_ctrl_seq #(
  parameter int               WIDTH   = 24,
  parameter int               FUNCT_W = 4,
  parameter int               OPC_W   = 4,
  parameter logic [OPC_W-1:0] MUL_OPC = OPC_W'(4'b0110)
) (
  input logic           clk,
  input logic           reset,
  alu_ctrl_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_count;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_out_valid;
  logic [3:0]           r_alu_ctrl;
  logic [WIDTH-1:0]     r_mul_result;
  logic                 r_mul_ovf;

  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_count_nxt;
  logic [2*WIDTH-1:0]   w_mcand_nxt;
  logic [WIDTH-1:0]     w_mplier_nxt;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic                 w_out_valid_nxt;
  logic [3:0]           w_alu_ctrl_nxt;
  logic [WIDTH-1:0]     w_mul_result_nxt;
  logic                 w_mul_ovf_nxt;

  logic [2*WIDTH-1:0]   w_acc_sum;
  logic                 w_is_mul;
  logic                 w_unsup;
  logic [3:0]           w_code;

`ifdef ALU_CTRL_ILLEGAL_EN
  logic                 r_illegal;
  logic                 w_illegal_nxt;
`endif

  assign bus.in_ready   = (r_state == ST_IDLE);
  assign bus.out_valid  = r_out_valid;
  assign bus.alu_ctrl   = r_alu_ctrl;
  assign bus.mul_result = r_mul_result;
  assign bus.mul_ovf    = r_mul_ovf;

  // One partial product per cycle: add the shifted multiplicand when the multiplier LSB is set.
  assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_is_mul = 1'b0;
    w_unsup  = 1'b0;
    w_code   = 4'b0010;
    case (bus.alu_op)
      2'b00: w_code = 4'b0010;
      2'b01: w_code = 4'b1010;
      2'b10: begin
        case (bus.funct)
          FUNCT_W'(4'b0010): w_code = 4'b0010;
          FUNCT_W'(4'b0011): w_code = 4'b1010;
          FUNCT_W'(4'b0000): w_code = 4'b0000;
          FUNCT_W'(4'b0001): w_code = 4'b0001;
          FUNCT_W'(4'b0100): w_code = 4'b1011;
          FUNCT_W'(4'b0110): w_code = 4'b0101;
          FUNCT_W'(4'b0111): w_code = 4'b0110;
          default:           w_unsup = 1'b1;
        endcase
      end
      default: begin
        if (bus.opcode == MUL_OPC) begin
          w_is_mul = 1'b1;
          w_code   = 4'b0100;
        end else begin
          w_unsup = 1'b1;
        end
      end
    endcase
    if (w_unsup) begin
`ifdef ALU_CTRL_ILLEGAL_EN
      w_code = 4'b0000;
`else
      w_code = 4'b0010;
`endif
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_mcand_nxt      = r_mcand;
    w_mplier_nxt     = r_mplier;
    w_acc_nxt        = r_acc;
    w_out_valid_nxt  = 1'b0;
    w_alu_ctrl_nxt   = r_alu_ctrl;
    w_mul_result_nxt = r_mul_result;
    w_mul_ovf_nxt    = r_mul_ovf;
`ifdef ALU_CTRL_ILLEGAL_EN
    w_illegal_nxt    = r_illegal;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (w_is_mul) begin
            w_state_nxt  = ST_MUL;
            w_count_nxt  = CNT_W'(WIDTH);
            w_mcand_nxt  = {{WIDTH{1'b0}}, bus.op_a};
            w_mplier_nxt = bus.op_b;
            w_acc_nxt    = '0;
          end else begin
            w_out_valid_nxt  = 1'b1;
            w_alu_ctrl_nxt   = w_code;
            w_mul_result_nxt = '0;
            w_mul_ovf_nxt    = 1'b0;
`ifdef ALU_CTRL_ILLEGAL_EN
            w_illegal_nxt    = w_unsup;
`endif
          end
        end
      end
      ST_MUL: begin
        w_acc_nxt    = w_acc_sum;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_count_nxt  = r_count - CNT_W'(1);
        // Fixed WIDTH-cycle latency: the result is published on the final iteration, no early exit.
        if (r_count == CNT_W'(1)) begin
          w_state_nxt      = ST_IDLE;
          w_out_valid_nxt  = 1'b1;
          w_alu_ctrl_nxt   = 4'b0100;
          w_mul_result_nxt = w_acc_sum[WIDTH-1:0];
          w_mul_ovf_nxt    = |w_acc_sum[2*WIDTH-1:WIDTH];
`ifdef ALU_CTRL_ILLEGAL_EN
          w_illegal_nxt    = 1'b0;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_acc        <= '0;
      r_out_valid  <= 1'b0;
      r_alu_ctrl   <= 4'b0000;
      r_mul_result <= '0;
      r_mul_ovf    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_mcand      <= w_mcand_nxt;
      r_mplier     <= w_mplier_nxt;
      r_acc        <= w_acc_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_alu_ctrl   <= w_alu_ctrl_nxt;
      r_mul_result <= w_mul_result_nxt;
      r_mul_ovf    <= w_mul_ovf_nxt;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_illegal_nxt;
    end
  end

  assign bus.illegal = r_illegal;
`else
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq; expectations follow ALU_CTRL_ILLEGAL_EN when defined.
module tb_alu_ctrl_seq;
  localparam int W = 24;

`ifdef ALU_CTRL_ILLEGAL_EN
  localparam logic [3:0] UNSUP_CODE = 4'b0000;
  localparam logic       UNSUP_ILL  = 1'b1;
`else
  localparam logic [3:0] UNSUP_CODE = 4'b0010;
  localparam logic       UNSUP_ILL  = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_ctrl_seq_if #(.WIDTH(W), .FUNCT_W(4), .OPC_W(4)) bus ();

  alu_ctrl_seq #(.WIDTH(W), .FUNCT_W(4), .OPC_W(4), .MUL_OPC(4'b0110)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.alu_op   = 2'b00;
    bus.funct    = 4'b0000;
    bus.opcode   = 4'b0000;
    bus.op_a     = '0;
    bus.op_b     = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.alu_ctrl !== 4'b0000 ||
        bus.mul_result !== '0 || bus.mul_ovf !== 1'b0 || bus.illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: ready=%b valid=%b ctrl=%b res=%h ovf=%b ill=%b, want 1 0 0000 0 0 0",
               bus.in_ready, bus.out_valid, bus.alu_ctrl, bus.mul_result, bus.mul_ovf, bus.illegal);
    end
  endtask

  task automatic test_decode();
    logic [1:0] ops   [11] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
    logic [3:0] fns   [11] = '{4'h0, 4'h0, 4'h2, 4'h3, 4'h0, 4'h1, 4'h4, 4'h6, 4'h7, 4'h0, 4'hF};
    logic [3:0] opcs  [11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 4'h0};
    logic [3:0] codes [11] = '{4'b0010, 4'b1010, 4'b0010, 4'b1010, 4'b0000, 4'b0001,
                               4'b1011, 4'b0101, 4'b0110, UNSUP_CODE, UNSUP_CODE};
    logic       ills  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, UNSUP_ILL, UNSUP_ILL};
    for (int i = 0; i < 11; i++) begin
      bus.in_valid = 1'b1;
      bus.alu_op   = ops[i];
      bus.funct    = fns[i];
      bus.opcode   = opcs[i];
      bus.op_a     = 24'h00ABCD;
      bus.op_b     = 24'h000003;
      tick();
      idle_inputs();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== codes[i] || bus.illegal !== ills[i] ||
          bus.mul_result !== '0 || bus.mul_ovf !== 1'b0) begin
        errors++;
        $display("[TB] FAIL decode_%0d: valid=%b ctrl=%b ill=%b res=%h ovf=%b, want 1 %b %b 0 0",
                 i, bus.out_valid, bus.alu_ctrl, bus.illegal, bus.mul_result, bus.mul_ovf, codes[i], ills[i]);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.alu_ctrl !== codes[i]) begin
        errors++;
        $display("[TB] FAIL decode_hold_%0d: valid=%b ctrl=%b, want 0 %b",
                 i, bus.out_valid, bus.alu_ctrl, codes[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bus.in_valid = 1'b1;
    bus.alu_op   = 2'b10;
    bus.funct    = 4'b0011;
    tick();
    bus.funct = 4'b0111;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 4'b1010 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_first: valid=%b ctrl=%b ready=%b, want 1 1010 1",
               bus.out_valid, bus.alu_ctrl, bus.in_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL b2b_second: valid=%b ctrl=%b, want 1 0110", bus.out_valid, bus.alu_ctrl);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.alu_ctrl !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL b2b_after: valid=%b ctrl=%b, want 0 0110", bus.out_valid, bus.alu_ctrl);
    end
  endtask

  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] expRes, input logic expOvf, input string name);
    int n;
    int busy;
    bus.in_valid = 1'b1;
    bus.alu_op   = 2'b11;
    bus.opcode   = 4'b0110;
    bus.op_a     = a;
    bus.op_b     = b;
    tick();
    idle_inputs();
    n    = 0;
    busy = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      if (bus.in_ready === 1'b0) busy++;
      tick();
      n++;
    end
    checks++;
    if (n != W || busy != W) begin
      errors++;
      $display("[TB] FAIL %s_latency: cycles=%0d busy=%0d, want %0d %0d", name, n, busy, W, W);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 4'b0100 || bus.mul_result !== expRes ||
        bus.mul_ovf !== expOvf || bus.illegal !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_result: valid=%b ctrl=%b res=%h ovf=%b ill=%b ready=%b, want 1 0100 %h %b 0 1",
               name, bus.out_valid, bus.alu_ctrl, bus.mul_result, bus.mul_ovf, bus.illegal,
               bus.in_ready, expRes, expOvf);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.mul_result !== expRes) begin
      errors++;
      $display("[TB] FAIL %s_pulse: valid=%b res=%h, want 0 %h", name, bus.out_valid, bus.mul_result, expRes);
    end
  endtask

  task automatic test_mul();
    run_mul(24'd1234, 24'd5678, 24'h6AE9BC, 1'b0, "mul_basic");
    run_mul(24'hFFFFFF, 24'h000002, 24'hFFFFFE, 1'b1, "mul_ovf");
    run_mul(24'h000000, 24'h123456, 24'h000000, 1'b0, "mul_zero");
  endtask

  task automatic test_ignore_busy();
    int pulses;
    int pulseAt;
    logic [3:0] seenCtrl;
    logic [W-1:0] seenRes;
    bus.in_valid = 1'b1;
    bus.alu_op   = 2'b11;
    bus.opcode   = 4'b0110;
    bus.op_a     = 24'd3;
    bus.op_b     = 24'd5;
    tick();
    bus.alu_op = 2'b00;
    bus.opcode = 4'b0000;
    pulses   = 0;
    pulseAt  = -1;
    seenCtrl = 4'hF;
    seenRes  = '1;
    for (int k = 0; k < W + 6; k++) begin
      if (k == 10) idle_inputs();
      if (bus.out_valid === 1'b1) begin
        pulses++;
        pulseAt  = k;
        seenCtrl = bus.alu_ctrl;
        seenRes  = bus.mul_result;
      end
      tick();
    end
    checks++;
    if (pulses != 1 || pulseAt != W || seenCtrl !== 4'b0100 || seenRes !== 24'd15) begin
      errors++;
      $display("[TB] FAIL ignore_busy: pulses=%0d at=%0d ctrl=%b res=%h, want 1 %0d 0100 00000f",
               pulses, pulseAt, seenCtrl, seenRes, W);
    end
  endtask

  task automatic test_reset_mid_mul();
    int pulses;
    bus.in_valid = 1'b1;
    bus.alu_op   = 2'b11;
    bus.opcode   = 4'b0110;
    bus.op_a     = 24'd1234;
    bus.op_b     = 24'd5678;
    tick();
    idle_inputs();
    repeat (9) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.alu_ctrl !== 4'b0000 || bus.mul_result !== '0 ||
        bus.mul_ovf !== 1'b0 || bus.illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_mul: valid=%b ctrl=%b res=%h ovf=%b ill=%b, want 0 0000 0 0 0",
               bus.out_valid, bus.alu_ctrl, bus.mul_result, bus.mul_ovf, bus.illegal);
    end
    tick();
    tick();
    reset  = 1'b0;
    pulses = 0;
    for (int k = 0; k < W + 4; k++) begin
      if (bus.out_valid === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_discard: pulses=%0d ready=%b, want 0 1", pulses, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.alu_op   = 2'b10;
    bus.funct    = 4'b0101;
    tick();
    idle_inputs();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== UNSUP_CODE || bus.illegal !== UNSUP_ILL) begin
      errors++;
      $display("[TB] FAIL unsup_after_reset: valid=%b ctrl=%b ill=%b, want 1 %b %b",
               bus.out_valid, bus.alu_ctrl, bus.illegal, UNSUP_CODE, UNSUP_ILL);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unsup_pulse: valid=%b, want 0", bus.out_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_decode();
    test_back_to_back();
    test_mul();
    test_ignore_busy();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Parametrised successor to the CPU's combinational ALU-control decoder.
- Accepts decode requests (ALUOp, Funct, opcode, two operands) over a valid/ready handshake and returns a registered ALUCtrl code.
- Executes MUL internally as an iterative shift-add over WIDTH cycles, stalling the front end while it runs.
- Sits between the control unit and the ALU in the datapath.

Parameters:
- WIDTH, 24, operand and result width in bits (>= 2).
- FUNCT_W, 4, R-format function-code width.
- OPC_W, 4, opcode width.
- MUL_OPC, 4'b0110, opcode that selects MUL when ALUOp = 2'b11.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request this cycle.
- alu_op  in  2  00 LW/SW/ADDI, 01 BEQ/BNE, 10 R-format, 11 I-format (MUL).
- funct  in  FUNCT_W  R-format function code.
- opcode  in  OPC_W  instruction opcode.
- op_a  in  WIDTH  multiplicand (used only for MUL).
- op_b  in  WIDTH  multiplier (used only for MUL).
- out_valid  out  1  one-cycle pulse: result fields are valid.
- alu_ctrl  out  4  decoded ALU control code.
- mul_result  out  WIDTH  low WIDTH bits of the product (0 for non-MUL).
- mul_ovf  out  1  high half of the product is nonzero (0 for non-MUL).
- illegal  out  1  unsupported encoding (see Optional Feature).

Behaviour:
- Reset (asynchronous, any state): state=IDLE, counter=0, out_valid=0, alu_ctrl=4'b0000, mul_result=0, mul_ovf=0, illegal=0. in_ready=1 once reset deasserts. An in-flight MUL is discarded and produces no out_valid.
- Accept: in_valid & in_ready at a rising edge. In_ready = (state==IDLE). in_valid while busy is ignored; the request is not latched.
- Decode table:
  - alu_op 00 -> 0010.
  - alu_op 01 -> 1010.
  - alu_op 10, funct 0010 -> 0010 (ADD).
  - alu_op 10, funct 0011 -> 1010 (SUB).
  - alu_op 10, funct 0000 -> 0000 (AND).
  - alu_op 10, funct 0001 -> 0001 (OR).
  - alu_op 10, funct 0100 -> 1011 (SLT).
  - alu_op 10, funct 0110 -> 0101 (XOR).
  - alu_op 10, funct 0111 -> 0110 (SLL).
  - alu_op 11, opcode==MUL_OPC -> 0100 (MUL).
  - Any other funct or opcode is an unsupported encoding.
- Non-MUL: accepted at edge E0. Outputs are registered at E0, so out_valid=1 in the cycle after E0. State stays IDLE, so back-to-back accepts give one result per cycle.
- MUL accept at E0:
  - Latch op_a and op_b; acc=0; counter=WIDTH; state->MUL.
  - Each MUL cycle: if multiplier LSB=1 then acc += multiplicand (2*WIDTH-bit).
  - Then multiplicand <<= 1, multiplier >>= 1, counter -= 1.
- MUL completion: at the edge where counter goes 1->0, state->IDLE.
  - Registered outputs: out_valid=1, alu_ctrl=0100, mul_result=acc[WIDTH-1:0], mul_ovf=|acc[2*WIDTH-1:WIDTH].
  - Latency: out_valid in the cycle after edge E_WIDTH, i.e. WIDTH cycles after accept.
  - in_ready returns to 1 in the same cycle as out_valid.
- Multiply is unsigned.
- out_valid lasts exactly one cycle; there is no output back-pressure.
- Result fields hold their last value while out_valid=0.
- Zero operand: still takes WIDTH cycles (fixed latency, no early exit).

Optional Feature:
- Macro: ALU_CTRL_ILLEGAL_EN.
- Defined: an unsupported encoding gives alu_ctrl=4'b0000 and illegal=1 with the out_valid pulse. illegal=0 on every legal result.
- Undefined: an unsupported encoding gives alu_ctrl=4'b0010 (add fallback). illegal is tied to 0.
- Latency is one cycle in both builds.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, alu_ctrl=0000, mul_result=0.
- alu_op=10, funct=0011, then funct=0111 on the next cycle (in_valid held) -> out_valid two consecutive cycles, alu_ctrl=1010 then 0110.
- alu_op=11, opcode=0110, op_a=1234, op_b=5678:
  - in_ready=0 for 24 cycles.
  - Then out_valid=1, alu_ctrl=0100, mul_result=0x6AE9BC, mul_ovf=0.
- MUL op_a=0xFFFFFF, op_b=0x000002 -> mul_result=0xFFFFFE, mul_ovf=1.
- in_valid with alu_op=00 asserted mid-MUL -> ignored. Only the MUL result appears, followed by no extra pulse.
- reset asserted on MUL cycle 10 -> outputs clear immediately and no out_valid. Then alu_op=10, funct=0101 -> alu_ctrl=0000/illegal=1 with the macro defined, alu_ctrl=0010/illegal=0 without.
